// File: rtl/magcomp_result_tracker.sv
// Result tracker behind the 4-bit magnitude comparator: saturating outcome counts, run length,
// last outcome, change pulse and latched fault. Optional run_irq output via MAGCOMP_RUN_IRQ_EN.
module magcomp_result_tracker #(
    parameter int CNT_W      = 8,
    parameter int RUN_W      = 4,
    parameter int RUN_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample,
    input  logic             clear,
    input  logic             greater,
    input  logic             less,
    input  logic             equal,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] lt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [RUN_W-1:0] run_len,
    output logic [1:0]       last_result,
    output logic             change,
    output logic             fault
`ifdef MAGCOMP_RUN_IRQ_EN
    ,
    output logic             run_irq
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_LT   = 2'b01;
    localparam logic [1:0] RES_GT   = 2'b10;
    localparam logic [1:0] RES_EQ   = 2'b11;

    if (RUN_THRESH < 1 || RUN_THRESH > (2**RUN_W) - 1) begin : g_bad_thresh
        $error("magcomp_result_tracker: RUN_THRESH outside 1..2^RUN_W-1");
    end

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
        return (v == {RUN_W{1'b1}}) ? v : v + RUN_W'(1);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [1:0]       last_q, last_d;
    logic             change_q, change_d;
    logic             fault_q, fault_d;
    logic             irq_q, irq_d;

    logic             legal;
    logic             same;
    logic [1:0]       code;

    always_comb begin
        legal    = ({greater, less, equal} == 3'b100) ||
                   ({greater, less, equal} == 3'b010) ||
                   ({greater, less, equal} == 3'b001);
        code     = greater ? RES_GT : (less ? RES_LT : RES_EQ);
        same     = (state_q == ST_TRACK) && (code == last_q);

        state_d  = state_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        run_d    = run_q;
        last_d   = last_q;
        change_d = 1'b0;
        fault_d  = fault_q;
        irq_d    = 1'b0;

        if (clear) begin
            state_d = ST_EMPTY;
            gt_d    = '0;
            lt_d    = '0;
            eq_d    = '0;
            run_d   = '0;
            last_d  = RES_NONE;
            fault_d = 1'b0;
        end else if (sample && state_q != ST_FAULT) begin
            if (legal) begin
                case (code)
                    RES_GT:  gt_d = sat_inc_cnt(gt_q);
                    RES_LT:  lt_d = sat_inc_cnt(lt_q);
                    default: eq_d = sat_inc_cnt(eq_q);
                endcase
                run_d    = same ? sat_inc_run(run_q) : RUN_W'(1);
                last_d   = code;
                change_d = (state_q == ST_TRACK) && !same;
                state_d  = ST_TRACK;
                // A fresh run reaching the threshold fires; a saturated repeat does not.
                irq_d    = (run_d == RUN_W'(RUN_THRESH)) && (!same || run_q != RUN_W'(RUN_THRESH));
            end else begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            gt_q     <= '0;
            lt_q     <= '0;
            eq_q     <= '0;
            run_q    <= '0;
            last_q   <= RES_NONE;
            change_q <= 1'b0;
            fault_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            run_q    <= run_d;
            last_q   <= last_d;
            change_q <= change_d;
            fault_q  <= fault_d;
            irq_q    <= irq_d;
        end
    end

    assign gt_count    = gt_q;
    assign lt_count    = lt_q;
    assign eq_count    = eq_q;
    assign run_len     = run_q;
    assign last_result = last_q;
    assign change      = change_q;
    assign fault       = fault_q;

`ifdef MAGCOMP_RUN_IRQ_EN
    assign run_irq = irq_q;
`else
    logic unused_irq;
    assign unused_irq = irq_q;
`endif

endmodule

// File: tb/tb_magcomp_result_tracker.sv
// Scoreboard bench for magcomp_result_tracker: directed vectors push hand-computed expectations,
// a clocked monitor pops and compares them. Compares run_irq when MAGCOMP_RUN_IRQ_EN is defined.
module tb_magcomp_result_tracker;

    typedef struct {
        string nm;
        int    gt, lt, eq, run, last, chg, flt, irq;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sample = 1'b0, clear = 1'b0, greater = 1'b0, less = 1'b0, equal = 1'b0;
    logic s_sample = 1'b0, s_clear = 1'b0, s_greater = 1'b0, s_less = 1'b0, s_equal = 1'b0;

    logic [7:0] gt_count, lt_count, eq_count;
    logic [3:0] run_len;
    logic [1:0] last_result;
    logic       change, fault;
    logic [1:0] s_gt_count, s_lt_count, s_eq_count, s_run_len, s_last_result;
    logic       s_change, s_fault;
`ifdef MAGCOMP_RUN_IRQ_EN
    logic       run_irq, s_run_irq;
`endif

    int checks = 0;
    int failures = 0;
    exp_t q_main[$];
    exp_t q_small[$];

    always #5 clk = ~clk;

    magcomp_result_tracker #(.CNT_W(8), .RUN_W(4), .RUN_THRESH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .sample(sample), .clear(clear),
        .greater(greater), .less(less), .equal(equal),
        .gt_count(gt_count), .lt_count(lt_count), .eq_count(eq_count),
        .run_len(run_len), .last_result(last_result), .change(change), .fault(fault)
`ifdef MAGCOMP_RUN_IRQ_EN
        , .run_irq(run_irq)
`endif
    );

    magcomp_result_tracker #(.CNT_W(2), .RUN_W(2), .RUN_THRESH(3)) u_small (
        .clk(clk), .rst_n(rst_n), .sample(s_sample), .clear(s_clear),
        .greater(s_greater), .less(s_less), .equal(s_equal),
        .gt_count(s_gt_count), .lt_count(s_lt_count), .eq_count(s_eq_count),
        .run_len(s_run_len), .last_result(s_last_result), .change(s_change), .fault(s_fault)
`ifdef MAGCOMP_RUN_IRQ_EN
        , .run_irq(s_run_irq)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic cmp_main(input exp_t e);
        chk({e.nm, " gt_count"}, int'(gt_count), e.gt);
        chk({e.nm, " lt_count"}, int'(lt_count), e.lt);
        chk({e.nm, " eq_count"}, int'(eq_count), e.eq);
        chk({e.nm, " run_len"}, int'(run_len), e.run);
        chk({e.nm, " last_result"}, int'(last_result), e.last);
        chk({e.nm, " change"}, int'(change), e.chg);
        chk({e.nm, " fault"}, int'(fault), e.flt);
`ifdef MAGCOMP_RUN_IRQ_EN
        chk({e.nm, " run_irq"}, int'(run_irq), e.irq);
`endif
    endtask

    // Monitor: every update issued before this edge is checked just after it.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q_main.size() > 0) begin
            e = q_main.pop_front();
            cmp_main(e);
        end
        if (q_small.size() > 0) begin
            e = q_small.pop_front();
            chk({e.nm, " gt_count"}, int'(s_gt_count), e.gt);
            chk({e.nm, " run_len"}, int'(s_run_len), e.run);
            chk({e.nm, " last_result"}, int'(s_last_result), e.last);
            chk({e.nm, " change"}, int'(s_change), e.chg);
            chk({e.nm, " fault"}, int'(s_fault), e.flt);
`ifdef MAGCOMP_RUN_IRQ_EN
            chk({e.nm, " run_irq"}, int'(s_run_irq), e.irq);
`endif
        end
    end

    task automatic step(input string nm, input logic s, input logic c, input logic [2:0] glE,
                        input int egt, input int elt, input int eeq, input int erun,
                        input int elast, input int echg, input int eflt, input int eirq);
        exp_t e;
        @(negedge clk);
        sample = s; clear = c; {greater, less, equal} = glE;
        e = '{nm, egt, elt, eeq, erun, elast, echg, eflt, eirq};
        q_main.push_back(e);
    endtask

    task automatic step_s(input string nm, input logic s, input logic [2:0] glE,
                          input int egt, input int erun, input int elast, input int echg,
                          input int eirq);
        exp_t e;
        @(negedge clk);
        s_sample = s; {s_greater, s_less, s_equal} = glE;
        e = '{nm, egt, 0, 0, erun, elast, echg, 0, eirq};
        q_small.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        z = '{"reset", 0, 0, 0, 0, 0, 0, 0, 0};
        repeat (3) @(posedge clk);
        #1 cmp_main(z);
        @(negedge clk) rst_n = 1'b1;

        // eq,eq,gt,lt,lt then idle
        step("seqA.1", 1, 0, 3'b001, 0, 0, 1, 1, 3, 0, 0, 0);
        step("seqA.2", 1, 0, 3'b001, 0, 0, 2, 2, 3, 0, 0, 0);
        step("seqA.3", 1, 0, 3'b100, 1, 0, 2, 1, 2, 1, 0, 0);
        step("seqA.4", 1, 0, 3'b010, 1, 1, 2, 1, 1, 1, 0, 0);
        step("seqA.5", 1, 0, 3'b010, 1, 2, 2, 2, 1, 0, 0, 0);
        step("seqA.idle", 0, 0, 3'b100, 1, 2, 2, 2, 1, 0, 0, 0);
        step("seqA.clr", 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset asserted between edges mid-run
        step("rst.1", 1, 0, 3'b001, 0, 0, 1, 1, 3, 0, 0, 0);
        step("rst.2", 1, 0, 3'b001, 0, 0, 2, 2, 3, 0, 0, 0);
        step("rst.3", 1, 0, 3'b001, 0, 0, 3, 3, 3, 0, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        sample = 1'b0;
        #1 z.nm = "async_rst";
        cmp_main(z);
        @(negedge clk) rst_n = 1'b1;
        step("rst.empty", 1, 0, 3'b100, 1, 0, 0, 1, 2, 0, 0, 0);
        step("rst.clr", 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);

        // illegal 110 after two legal samples freezes everything
        step("flt.1", 1, 0, 3'b100, 1, 0, 0, 1, 2, 0, 0, 0);
        step("flt.2", 1, 0, 3'b100, 2, 0, 0, 2, 2, 0, 0, 0);
        step("flt.bad", 1, 0, 3'b110, 2, 0, 0, 2, 2, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            step("flt.ign", 1, 0, 3'b010, 2, 0, 0, 2, 2, 0, 1, 0);
        step("flt.clr", 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        step("flt.after", 1, 0, 3'b001, 0, 0, 1, 1, 3, 0, 0, 0);

        // clear beats a simultaneous sample
        step("clrs.clr", 1, 1, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0);
        step("clrs.idle", 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0);

        // illegal 000 straight from EMPTY
        step("f000", 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0);
        step("f000.clr", 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);

        // run threshold: 6 less, 1 greater, 4 less
        for (int i = 1; i <= 6; i++)
            step("irq.lt", 1, 0, 3'b010, 0, i, 0, i, 1, 0, 0, (i == 4) ? 1 : 0);
        step("irq.gt", 1, 0, 3'b100, 1, 6, 0, 1, 2, 1, 0, 0);
        for (int i = 1; i <= 4; i++)
            step("irq.lt2", 1, 0, 3'b010, 1, 6 + i, 0, i, 1, (i == 1) ? 1 : 0, 0,
                 (i == 4) ? 1 : 0);
        step("irq.idle", 0, 0, 3'b000, 1, 10, 0, 4, 1, 0, 0, 0);

        // narrow instance: 6 greater saturate count and run at 3
        for (int i = 1; i <= 6; i++)
            step_s("sat.gt", 1, 3'b100, (i < 3) ? i : 3, (i < 3) ? i : 3, 2, 0,
                   (i == 3) ? 1 : 0);
        step_s("sat.idle", 0, 3'b000, 3, 3, 2, 0, 0);

        @(negedge clk);
        sample = 1'b0; s_sample = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", q_main.size() + q_small.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
